// File: rtl/butterfly_pkg.sv
// Shared definitions for the FFT butterfly and its frame-level sequencer.
package butterfly_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } seq_state_t;

  // Counter or index width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/operand_buffer.sv
// Frame operand store: one sequential write port, two combinational read
// ports returning the a/b operands of pair rd_idx.
module operand_buffer
  import butterfly_pkg::*;
#(
  parameter  int N_PAIRS = 8,
  parameter  int DATA_W  = butterfly_pkg::DATA_W,
  localparam int DEPTH   = 2 * N_PAIRS,
  localparam int AW      = clog2_min1(DEPTH),
  localparam int KW      = clog2_min1(N_PAIRS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [KW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     addr_a;
  logic [AW-1:0]     addr_b;

  // NOTE: storage is deliberately not reset; the write pointer alone decides
  // which entries are valid, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign addr_a = AW'({rd_idx, 1'b0});
  assign addr_b = AW'({rd_idx, 1'b1});
  assign rd_a   = mem[addr_a];
  assign rd_b   = mem[addr_b];

endmodule

// File: rtl/butterfly_sequencer.sv
// Buffers a frame of operand pairs and issues them one at a time to an
// fft_butterfly over start/done, forwarding each result on a valid/ready stream.
module butterfly_sequencer #(
  parameter int N_PAIRS      = 8,
  parameter int DATA_W       = butterfly_pkg::DATA_W,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic              bf_start,
  output logic [DATA_W-1:0] bf_in_a,
  output logic [DATA_W-1:0] bf_in_b,
  input  logic [DATA_W-1:0] bf_result,
  input  logic              bf_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_last
);

  import butterfly_pkg::*;

  localparam int DEPTH = 2 * N_PAIRS;
  localparam int AW    = clog2_min1(DEPTH);
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int KW    = clog2_min1(N_PAIRS);
  localparam int TW    = clog2_min1(DONE_TIMEOUT);

  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);
  localparam logic [KW-1:0] LAST_K   = KW'(N_PAIRS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [KW-1:0]     k_q, k_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              full_q, full_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic              bf_start_q, bf_start_d;
  logic [DATA_W-1:0] bf_in_a_q, bf_in_a_d;
  logic [DATA_W-1:0] bf_in_b_q, bf_in_b_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_last_q, res_last_d;

  logic              buf_we;
  logic [KW-1:0]     rd_idx;
  logic [DATA_W-1:0] rd_a, rd_b;

  // Pair about to be issued: 0 when leaving IDLE, k+1 when leaving OUT.
  assign rd_idx = (state_q == OUT) ? k_q + 1'b1 : '0;

  operand_buffer #(
    .N_PAIRS (N_PAIRS),
    .DATA_W  (DATA_W)
  ) u_operand_buffer (
    .clk    (clk),
    .we     (buf_we),
    .waddr  (AW'(wr_ptr_q)),
    .wdata  (wr_data),
    .rd_idx (rd_idx),
    .rd_a   (rd_a),
    .rd_b   (rd_b)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    k_d          = k_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    bf_start_d   = 1'b0;
    bf_in_a_d    = bf_in_a_q;
    bf_in_b_d    = bf_in_b_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_last_d   = res_last_q;
    buf_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_en && !full_q) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (frame_start && full_q) begin
          err_d      = 1'b0;
          k_d        = '0;
          state_d    = ISSUE;
          bf_start_d = 1'b1;
          bf_in_a_d  = rd_a;
          bf_in_b_d  = rd_b;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done on the expiring cycle still counts as success.
        if (bf_done) begin
          res_data_d  = bf_result;
          res_valid_d = 1'b1;
          res_last_d  = (k_q == LAST_K);
          state_d     = OUT;
        end else if (tmo_q == TMO_LAST) begin
          err_d        = 1'b1;
          frame_done_d = 1'b1;
          wr_ptr_d     = '0;
          state_d      = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          if (res_last_q) begin
            frame_done_d = 1'b1;
            wr_ptr_d     = '0;
            state_d      = IDLE;
          end else begin
            k_d        = k_q + 1'b1;
            state_d    = ISSUE;
            bf_start_d = 1'b1;
            bf_in_a_d  = rd_a;
            bf_in_b_d  = rd_b;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    full_d = (wr_ptr_d == PTR_FULL);
    busy_d = (state_d != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      k_q          <= '0;
      tmo_q        <= '0;
      full_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      bf_start_q   <= 1'b0;
      bf_in_a_q    <= '0;
      bf_in_b_q    <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      k_q          <= k_d;
      tmo_q        <= tmo_d;
      full_q       <= full_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      bf_start_q   <= bf_start_d;
      bf_in_a_q    <= bf_in_a_d;
      bf_in_b_q    <= bf_in_b_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_last_q   <= res_last_d;
    end
  end

  assign full       = full_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign bf_start   = bf_start_q;
  assign bf_in_a    = bf_in_a_q;
  assign bf_in_b    = bf_in_b_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_last   = res_last_q;

endmodule

// File: tb/tb_butterfly_sequencer.sv
// Directed bench for butterfly_sequencer with N_PAIRS=2 and a behavioural
// butterfly that returns a+b a programmable number of cycles after start.
module tb_butterfly_sequencer;

  localparam int N_PAIRS = 2;
  localparam int DATA_W  = 8;
  localparam int TMO     = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              frame_start;
  logic              busy;
  logic              frame_done;
  logic              err;
  logic              bf_start;
  logic [DATA_W-1:0] bf_in_a;
  logic [DATA_W-1:0] bf_in_b;
  logic [DATA_W-1:0] bf_result;
  logic              bf_done;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_last;

  int tests = 0;
  int fails = 0;

  // Butterfly model controls
  logic              bf_en  = 1'b1;
  int                bf_lat = 3;
  int                lat_cnt = 0;
  logic [DATA_W-1:0] op_a = '0;
  logic [DATA_W-1:0] op_b = '0;

  butterfly_sequencer #(
    .N_PAIRS      (N_PAIRS),
    .DATA_W       (DATA_W),
    .DONE_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .frame_start (frame_start),
    .busy        (busy),
    .frame_done  (frame_done),
    .err         (err),
    .bf_start    (bf_start),
    .bf_in_a     (bf_in_a),
    .bf_in_b     (bf_in_b),
    .bf_result   (bf_result),
    .bf_done     (bf_done),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_last    (res_last)
  );

  always #5 clk = ~clk;

  // Start seen in cycle S -> done high during cycle S+bf_lat.
  initial begin
    bf_done   = 1'b0;
    bf_result = '0;
  end

  always @(negedge clk) begin
    if (bf_start && bf_en) begin
      lat_cnt = bf_lat;
      op_a    = bf_in_a;
      op_b    = bf_in_b;
      bf_done = 1'b0;
    end else if (lat_cnt > 1) begin
      lat_cnt = lat_cnt - 1;
      bf_done = 1'b0;
    end else if (lat_cnt == 1) begin
      lat_cnt   = 0;
      bf_done   = 1'b1;
      bf_result = op_a + op_b;
    end else begin
      bf_done = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_op(input logic [DATA_W-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic fill(input logic [DATA_W-1:0] a0, input logic [DATA_W-1:0] b0,
                      input logic [DATA_W-1:0] a1, input logic [DATA_W-1:0] b1);
    write_op(a0);
    write_op(b0);
    write_op(a1);
    write_op(b1);
  endtask

  // Returns in the cycle where bf_start should be high.
  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"},      busy,      1'b0);
    check({tag, ".full"},      full,      1'b0);
    check({tag, ".fdone"},     frame_done, 1'b0);
    check({tag, ".err"},       err,       1'b0);
    check({tag, ".bf_start"},  bf_start,  1'b0);
    check({tag, ".bf_in_a"},   bf_in_a,   '0);
    check({tag, ".bf_in_b"},   bf_in_b,   '0);
    check({tag, ".res_valid"}, res_valid, 1'b0);
    check({tag, ".res_data"},  res_data,  '0);
    check({tag, ".res_last"},  res_last,  1'b0);
  endtask

  initial begin
    rst         = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    frame_start = 1'b0;
    res_ready   = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b1;
    tick();

    // Fill buffer; full only after the 4th write, 5th write dropped.
    write_op(8'd1);
    write_op(8'd2);
    write_op(8'd3);
    check("full_before_4th", full, 1'b0);
    write_op(8'd4);
    check("full_after_4th", full, 1'b1);
    write_op(8'hAA);
    check("full_after_5th", full, 1'b1);

    // Nominal frame, latency 3, frame_start re-asserted while busy.
    bf_en  = 1'b1;
    bf_lat = 3;
    res_ready = 1'b1;
    start_frame();
    check("nom.p0.bf_start", bf_start, 1'b1);
    check("nom.p0.busy",     busy,     1'b1);
    check("nom.p0.in_a",     bf_in_a,  8'd1);
    check("nom.p0.in_b",     bf_in_b,  8'd2);
    frame_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nom.busy_start", bf_start, 1'b0);
      check("nom.p0.wait_valid", res_valid, 1'b0);
    end
    frame_start = 1'b0;
    tick();
    check("nom.p0.valid", res_valid, 1'b1);
    check("nom.p0.data",  res_data,  8'd3);
    check("nom.p0.last",  res_last,  1'b0);
    tick();
    check("nom.p1.bf_start", bf_start,  1'b1);
    check("nom.p1.in_a",     bf_in_a,   8'd3);
    check("nom.p1.in_b",     bf_in_b,   8'd4);
    check("nom.p1.valid_lo", res_valid, 1'b0);
    repeat (4) tick();
    check("nom.p1.valid", res_valid, 1'b1);
    check("nom.p1.data",  res_data,  8'd7);
    check("nom.p1.last",  res_last,  1'b1);
    check("nom.p1.fdone_early", frame_done, 1'b0);
    tick();
    check("nom.fdone",     frame_done, 1'b1);
    check("nom.busy_end",  busy,       1'b0);
    check("nom.full_end",  full,       1'b0);
    check("nom.valid_end", res_valid,  1'b0);
    tick();
    check("nom.fdone_pulse", frame_done, 1'b0);

    // Backpressure on pair 0 for 5 cycles.
    fill(8'd5, 8'd6, 8'd7, 8'd8);
    res_ready = 1'b0;
    start_frame();
    check("bp.p0.bf_start", bf_start, 1'b1);
    repeat (4) tick();
    check("bp.p0.valid", res_valid, 1'b1);
    check("bp.p0.data",  res_data,  8'd11);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.hold.valid",    res_valid, 1'b1);
      check("bp.hold.data",     res_data,  8'd11);
      check("bp.hold.bf_start", bf_start,  1'b0);
    end
    res_ready = 1'b1;
    tick();
    check("bp.p1.bf_start", bf_start, 1'b1);
    check("bp.p1.in_a",     bf_in_a,  8'd7);
    repeat (4) tick();
    check("bp.p1.data", res_data, 8'd15);
    check("bp.p1.last", res_last, 1'b1);
    tick();
    check("bp.fdone", frame_done, 1'b1);

    // Timeout: butterfly silent.
    fill(8'd9, 8'd10, 8'd11, 8'd12);
    bf_en = 1'b0;
    start_frame();
    check("tmo.bf_start", bf_start, 1'b1);
    for (int i = 1; i <= TMO; i++) begin
      tick();
      check("tmo.fdone_early", frame_done, 1'b0);
      check("tmo.err_early",   err,        1'b0);
      check("tmo.valid",       res_valid,  1'b0);
    end
    tick();
    check("tmo.fdone", frame_done, 1'b1);
    check("tmo.err",   err,        1'b1);
    check("tmo.busy",  busy,       1'b0);
    check("tmo.valid_end", res_valid, 1'b0);
    check("tmo.full",  full,       1'b0);
    tick();
    check("tmo.fdone_pulse", frame_done, 1'b0);
    check("tmo.err_sticky",  err,        1'b1);

    // Done on the final timeout cycle wins; new frame clears err.
    fill(8'h10, 8'h20, 8'h30, 8'h40);
    check("edge.err_before", err, 1'b1);
    bf_en  = 1'b1;
    bf_lat = TMO;
    start_frame();
    check("edge.err_cleared", err, 1'b0);
    check("edge.bf_start",    bf_start, 1'b1);
    repeat (TMO) tick();
    check("edge.p0.valid_lo", res_valid, 1'b0);
    tick();
    check("edge.p0.valid", res_valid,  1'b1);
    check("edge.p0.data",  res_data,   8'h30);
    check("edge.p0.fdone", frame_done, 1'b0);
    check("edge.p0.err",   err,        1'b0);
    tick();
    check("edge.p1.bf_start", bf_start, 1'b1);
    repeat (TMO + 1) tick();
    check("edge.p1.data", res_data, 8'h70);
    check("edge.p1.last", res_last, 1'b1);
    tick();
    check("edge.fdone", frame_done, 1'b1);
    check("edge.err",   err,        1'b0);

    // Reset mid-WAIT, then frame_start on an empty buffer.
    bf_lat = 3;
    fill(8'd1, 8'd1, 8'd1, 8'd1);
    start_frame();
    tick();
    check("rstw.busy_pre", busy, 1'b1);
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    tick();
    check_idle_outputs("rst_mid");
    rst = 1'b1;
    tick();
    start_frame();
    check("empty.bf_start", bf_start, 1'b0);
    check("empty.busy",     busy,     1'b0);
    tick();
    check("empty.bf_start2", bf_start, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/butterfly_sequencer.md
# butterfly_sequencer

Frame-level initiator for the `fft_butterfly` start/done interface. It buffers a frame of operand pairs written by the host and issues them one pair at a time to the butterfly: drive `in_a`/`in_b`, pulse `start`, wait for `done`, then capture `result`. Each captured result is forwarded on a valid/ready output stream. The block sits between the host operand source and one `fft_butterfly` instance.

## Interface
- `N_PAIRS`, 8: operand pairs per frame (≥1).
- `DATA_W`, 8: operand/result width; must match the butterfly.
- `DONE_TIMEOUT`, 15: maximum WAIT cycles before abort (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (`rst`=0 resets).
- `wr_en` in 1: host operand write strobe.
- `wr_data` in DATA_W: operand; writes alternate a, b, a, b… by write order.
- `full` out 1: buffer holds 2·N_PAIRS operands.
- `frame_start` in 1: begin sequencing; accepted only when `full` and IDLE.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse at frame end (normal or abort).
- `err` out 1: sticky timeout flag; cleared by the next accepted `frame_start`.
- `bf_start` out 1: one-cycle start pulse to the butterfly.
- `bf_in_a`, `bf_in_b` out DATA_W: operands, held stable from ISSUE through WAIT.
- `bf_result` in DATA_W: butterfly result.
- `bf_done` in 1: butterfly completion, sampled as a level in WAIT.
- `res_valid` out 1, `res_ready` in 1, `res_data` out DATA_W, `res_last` out 1: result stream.

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - `wr_en` writes `wr_data` at `wr_ptr` and increments `wr_ptr`.
  - Writes are ignored when `full` and in every non-IDLE state.
  - `frame_start` with `full`: clear `err`, set `k`=0, go to ISSUE.
  - `frame_start` without `full` is ignored.
- ISSUE (1 cycle):
  - `bf_start`=1; `bf_in_a`=buf[2k], `bf_in_b`=buf[2k+1].
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - `bf_done`=1: register `bf_result` into `res_data` and go to OUT.
  - Otherwise increment the counter. When it reaches DONE_TIMEOUT without `bf_done`: set `err`, pulse `frame_done`, clear `wr_ptr`, go to IDLE. No result is emitted for the failed pair.
  - If `bf_done` is seen on the same cycle the count would expire, `bf_done` wins.
- OUT:
  - `res_valid`=1; `res_last`=1 when k=N_PAIRS−1.
  - `res_data` is held while `res_ready`=0.
  - On handshake (`res_valid`&`res_ready`): if last, pulse `frame_done`, clear `wr_ptr`, go to IDLE. Otherwise increment `k` and go to ISSUE.
- A `bf_done` outside WAIT is ignored.
- `frame_start` while busy is ignored.
- The buffer is cleared logically (pointer only) after each frame; data RAM is not zeroed.

## Timing
- Reset values:
  - State IDLE, `wr_ptr`=0, `k`=0.
  - `full`=0, `busy`=0, `frame_done`=0, `err`=0.
  - `bf_start`=0, `bf_in_a`=0, `bf_in_b`=0.
  - `res_valid`=0, `res_data`=0, `res_last`=0.
- All outputs are registered.
- `full` rises the cycle after the 2·N_PAIRS-th accepted write.
- `frame_start` sampled at edge T → `bf_start` high during T+1.
- `bf_done` sampled at edge D → `res_valid` high from D+1.
- Handshake at edge H → next `bf_start` high during H+1. Minimum pair period is therefore 3 cycles plus butterfly latency.
- Final handshake at edge H → `frame_done`=1 and `busy`=0 during H+1.
- Timeout: `bf_start` in cycle S → abort edge at S+DONE_TIMEOUT → `frame_done` and `err` high the cycle after.
- Reset asserted mid-frame returns all state to reset values immediately; buffered operands are discarded.

## Structure
- Shared `butterfly_pkg`:
  - `seq_state_t` enum (IDLE, ISSUE, WAIT, OUT).
  - Default `DATA_W` localparam, also used by `fft_butterfly`.
- One sub-module, `operand_buffer`: 2·N_PAIRS × DATA_W register file with a sequential write port and two combinational read ports (2k, 2k+1).
- FSM, counters and stream register live in the top.

## Test plan
- Reset and idle:
  - Assert `rst`=0 mid-WAIT → all outputs 0 next cycle and `full`=0.
  - `frame_start` afterwards (buffer empty) → no `bf_start`.
- Nominal frame, N_PAIRS=2:
  - Write 1,2,3,4; butterfly model returns a+b after 3 cycles; `res_ready`=1.
  - Expect `res_data` 3 then 7, `res_last` on 7, `frame_done` one cycle after the second handshake.
- Backpressure: hold `res_ready`=0 for 5 cycles on pair 0 → `res_data` stable, no second `bf_start` until the handshake.
- Timeout:
  - Butterfly never asserts done → `err`=1 and `frame_done` pulse exactly DONE_TIMEOUT+1 cycles after `bf_start`; no `res_valid`.
  - Next `frame_start` clears `err`.
- Boundary:
  - A 5th write when full is ignored (`res_data` still from the first 4).
  - `frame_start` while busy is ignored.
  - `bf_done` on the final timeout cycle → result emitted, `err`=0.
